// File: rtl/hypot_pkg.sv
// hypot_pkg: state encoding and width helpers shared by the hypot sequencer.
package hypot_pkg;
    localparam int W_DEF = 8;
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SQX  = 3'd1,
        SQY  = 3'd2,
        ROOT = 3'd3,
        DONE = 3'd4
    } state_t;
    function automatic int sum_w(input int w);
        return 2 * w + 1;
    endfunction
    function automatic int res_w(input int w);
        return w + 1;
    endfunction
    function automatic int rem_w(input int w);
        return w + 3;
    endfunction
    localparam int SUM_W = sum_w(W_DEF);
    localparam int RES_W = res_w(W_DEF);
    localparam int REM_W = rem_w(W_DEF);
endpackage

// File: rtl/hypot_isqrt_step.sv
// hypot_isqrt_step: one digit-by-digit square-root iteration (one result bit per call).
module hypot_isqrt_step
    import hypot_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [rem_w(W)-1:0] rem,
    input  logic [res_w(W)-1:0] root,
    input  logic [1:0]          pair,
    output logic [rem_w(W)-1:0] rem_nx,
    output logic [res_w(W)-1:0] root_nx
);
    localparam int RMW = rem_w(W);
    localparam int RSW = res_w(W);
    logic [RMW-1:0] rem_sh;
    logic [RMW-1:0] trial;
    logic           ge;
    always_comb begin
        rem_sh  = {rem[RMW-3:0], pair};
        trial   = {root, 2'b01};
        ge      = rem_sh >= trial;
        rem_nx  = ge ? rem_sh - trial : rem_sh;
        root_nx = {root[RSW-2:0], ge};
    end
endmodule

// File: rtl/hypot_seq_ctrl.sv
// hypot_seq_ctrl: sequential floor(sqrt(x^2+y^2)) using one shared multiplier and an
// iterative square root, with valid/ready handshakes on both sides.
module hypot_seq_ctrl
    import hypot_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W-1:0]        x_in,
    input  logic [W-1:0]        y_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [res_w(W)-1:0] mag_out,
    output logic                busy
);
    localparam int SW  = sum_w(W);
    localparam int RSW = res_w(W);
    localparam int RMW = rem_w(W);
    localparam int CW  = $clog2(W + 1);
    state_t         state, state_nx;
    logic [W-1:0]   x, y;
    logic [SW-1:0]  sum;
    logic [SW:0]    sum_ext;
    logic [RMW-1:0] rem, rem_nx;
    logic [RSW-1:0] root, root_nx;
    logic [CW-1:0]  count;
    logic [2*W-1:0] mul_op, prod;
    logic [1:0]     pair;
    always_comb begin
        state_nx = state == IDLE ? (in_valid ? SQX : IDLE) :
                   state == SQX  ? SQY :
                   state == SQY  ? ROOT :
                   state == ROOT ? (count == '0 ? DONE : ROOT) :
                   state == DONE ? (out_ready ? IDLE : DONE) : IDLE;
        in_ready  = state == IDLE;
        out_valid = state == DONE;
        busy      = state != IDLE;
        mul_op    = {{W{1'b0}}, state == SQX ? x : y};
        prod      = mul_op * mul_op;
        sum_ext   = {1'b0, sum};
        pair      = sum_ext[{count, 1'b0} +: 2];
    end
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    hypot_isqrt_step #(.W(W)) u_step (
        .rem     (rem),
        .root    (root),
        .pair    (pair),
        .rem_nx  (rem_nx),
        .root_nx (root_nx)
    );
    // Operands are only sampled on an accepted handshake; the sum pair index is count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x       <= '0;
            y       <= '0;
            sum     <= '0;
            rem     <= '0;
            root    <= '0;
            count   <= '0;
            mag_out <= '0;
        end else begin
            if (state == IDLE && in_valid) begin
                x <= x_in;
                y <= y_in;
            end
            if (state == SQX) sum <= SW'(prod);
            if (state == SQY) begin
                sum   <= sum + SW'(prod);
                rem   <= '0;
                root  <= '0;
                count <= CW'(W);
            end
            if (state == ROOT) begin
                rem   <= rem_nx;
                root  <= root_nx;
                count <= count - 1'b1;
                if (count == '0) mag_out <= root_nx;
            end
        end
    end
endmodule

// File: tb/tb_hypot_seq_ctrl.sv
// tb_hypot_seq_ctrl: scoreboard bench comparing the sequencer with an integer sqrt model.
module tb_hypot_seq_ctrl;
    localparam int W = 8;
    localparam int LAT = W + 3;
    logic         clk = 0;
    logic         rst_n = 0;
    logic         in_valid = 0;
    logic         in_ready;
    logic [W-1:0] x_in = '0;
    logic [W-1:0] y_in = '0;
    logic         out_valid;
    logic         out_ready = 1;
    logic [W:0]   mag_out;
    logic         busy;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_q[$];
    int start_q[$];
    logic prev_ov = 0;
    logic hs_prev = 0;

    hypot_seq_ctrl #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mag_out   (mag_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int isqrt(input int s);
        int r = 0;
        while ((r + 1) * (r + 1) <= s) r++;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Input side: every accepted pair pushes its reference result and handshake edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            start_q.delete();
            hs_prev = 0;
        end else begin
            if (hs_prev) chk("in_ready_drop", int'(in_ready), 0);
            chk("busy_vs_idle", int'(busy), int'(!in_ready));
            hs_prev = in_valid && in_ready;
            if (hs_prev) begin
                exp_q.push_back(isqrt(int'(x_in) * int'(x_in) + int'(y_in) * int'(y_in)));
                start_q.push_back(cyc + 1);
            end
        end
    end

    // Output side: each new result is popped and compared on its first valid cycle.
    always @(negedge clk) begin
        if (!rst_n) prev_ov = 0;
        else begin
            if (out_valid && !prev_ov) begin
                if (exp_q.size() == 0) chk("spurious_out_valid", 1, 0);
                else begin
                    chk("mag_out", int'(mag_out), exp_q.pop_front());
                    chk("latency", cyc - start_q.pop_front(), LAT);
                end
            end
            prev_ov = out_valid;
        end
    end

    task automatic send(input int x, input int y);
        int t = 0;
        in_valid = 1;
        x_in = W'(x);
        y_in = W'(y);
        while (!in_ready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) chk("send_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || !in_ready) && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        chk("drain_done", int'(exp_q.size() == 0 && in_ready), 1);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_in_ready"}, int'(in_ready), 1);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_mag_out"}, int'(mag_out), 0);
    endtask

    initial begin
        int t;
        int seqx[6] = '{5, 6, 7, 0, 1, 255};
        int seqy[6] = '{12, 8, 24, 0, 1, 255};
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        check_idle("reset");

        send(3, 4);
        drain();
        chk("res_3_4", int'(mag_out), 5);

        for (int i = 0; i < 6; i++) send(seqx[i], seqy[i]);
        drain();
        chk("res_255_255", int'(mag_out), 360);

        out_ready = 0;
        send(8, 15);
        t = 0;
        while (!out_valid && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk("bp_valid_seen", int'(out_valid), 1);
        for (int i = 0; i < 20; i++) begin
            in_valid = 1;
            x_in = W'($urandom);
            y_in = W'($urandom);
            @(negedge clk);
            chk("bp_out_valid", int'(out_valid), 1);
            chk("bp_mag_out", int'(mag_out), 17);
            chk("bp_in_ready", int'(in_ready), 0);
            @(posedge clk); #1;
        end
        in_valid = 0;
        out_ready = 1;
        @(posedge clk); #1;
        chk("bp_release_valid", int'(out_valid), 0);
        chk("bp_release_ready", int'(in_ready), 1);
        chk("bp_retain_mag", int'(mag_out), 17);

        send(200, 100);
        repeat (4) @(posedge clk);
        #1 rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        check_idle("midop_reset");
        send(3, 4);
        drain();
        chk("post_reset_3_4", int'(mag_out), 5);

        for (int i = 0; i < 1000; i++) begin
            send($urandom_range(0, 255), $urandom_range(0, 255));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
